// File: rtl/reg_file_32x32_pkg.sv
// Shared sizing constants and index type for the 32x32 register file slice.
package reg_file_32x32_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 2 ** DEF_ADDR_W;
  localparam int unsigned ZERO_REG   = 0;

  typedef logic [DEF_ADDR_W-1:0] reg_idx_t;

endpackage

// File: rtl/reg_file_32x32_bit32_reg_en.sv
// One register-file entry: load-enabled storage with asynchronous active-low clear.
module bit32_reg_en
  import reg_file_32x32_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_DATA_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/reg_file_32x32.sv
// Register file: 2**ADDR_W entries, entry 0 hardwired to zero, two combinational
// read ports with optional same-cycle write bypass, one synchronous write port.
module reg_file_32x32
  import reg_file_32x32_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2
);

  localparam int unsigned REG_CNT = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0]  regs [REG_CNT];
  logic [REG_CNT-1:1] load_en;
  logic               wr_live;
  logic               hit1;
  logic               hit2;

  // Entry 0 has no storage; it is a constant zero.
  assign regs[0] = '0;

  // One-hot decode: an unknown wr_en can only reach the addressed entry.
  always_comb begin
    load_en = '0;
    for (int unsigned i = 1; i < REG_CNT; i++) begin
      load_en[i] = wr_en && (wr_addr == ADDR_W'(i));
    end
  end

  for (genvar g = 1; g < REG_CNT; g++) begin : g_entry
    bit32_reg_en #(
      .WIDTH(DATA_W)
    ) u_entry (
      .clk  (clk),
      .rst_n(rst_n),
      .load (load_en[g]),
      .d    (wr_data),
      .q    (regs[g])
    );
  end

  // Bypass is suppressed under reset so every address reads zero while rst_n is low.
  always_comb begin
    wr_live = (BYPASS != 0) && rst_n && wr_en && (wr_addr != ZERO_IDX);
    hit1    = wr_live && (rd_addr1 == wr_addr);
    hit2    = wr_live && (rd_addr2 == wr_addr);
  end

  always_comb begin
    rd_data1 = '0;
    if (rd_addr1 != ZERO_IDX) begin
      rd_data1 = hit1 ? wr_data : regs[rd_addr1];
    end
  end

  always_comb begin
    rd_data2 = '0;
    if (rd_addr2 != ZERO_IDX) begin
      rd_data2 = hit2 ? wr_data : regs[rd_addr2];
    end
  end

endmodule
